// File: rtl/mult_acc_8_bit.sv
// 8x8 unsigned shift-add multiplier feeding a wrapping accumulator with a sticky overflow flag.
// One operand pair is processed at a time through IDLE -> MUL (8 steps) -> ACC -> DONE.
module mult_acc_8_bit #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             clear_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic [ACC_W-1:0] acc,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       mcand;
  logic [7:0]       mplier;
  logic [7:0]       hi;
  logic [7:0]       lo;
  logic [2:0]       step;
  logic             clear_latched;

  logic [8:0]       sum9;
  logic [7:0]       hi_next;
  logic [7:0]       lo_next;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;

  // One shift-add step: the carry of the add drops into hi, hi's LSB into lo.
  always_comb begin
    sum9     = {1'b0, hi} + (mplier[0] ? {1'b0, mcand} : 9'd0);
    hi_next  = sum9[8:1];
    lo_next  = {sum9[0], lo[7:1]};
    acc_base = clear_latched ? '0 : acc;
    acc_sum  = {1'b0, acc_base} + {{(ACC_W - 15){1'b0}}, product};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      mcand         <= '0;
      mplier        <= '0;
      hi            <= '0;
      lo            <= '0;
      step          <= '0;
      clear_latched <= 1'b0;
      product       <= '0;
      acc           <= '0;
      overflow      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand         <= a;
            mplier        <= b;
            clear_latched <= clear_acc;
            hi            <= '0;
            lo            <= '0;
            step          <= '0;
            state         <= MUL;
          end
        end
        MUL: begin
          hi     <= hi_next;
          lo     <= lo_next;
          mplier <= {1'b0, mplier[7:1]};
          step   <= step + 3'd1;
          if (step == 3'd7) begin
            product <= {hi_next, lo_next};
            state   <= ACC;
          end
        end
        ACC: begin
          acc <= acc_sum[ACC_W-1:0];
          // A clearing step restarts the sticky flag from this add's carry alone.
          overflow <= clear_latched ? acc_sum[ACC_W] : (overflow | acc_sum[ACC_W]);
          state    <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_acc_8_bit.sv
// Directed bench for mult_acc_8_bit: vector table of single operations plus stall,
// mid-operation reset and back-to-back throughput sequences.
module tb_mult_acc_8_bit;

  localparam int ACC_W = 20;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       a;
  logic [7:0]       b;
  logic             clear_acc;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      product;
  logic [ACC_W-1:0] acc;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  mult_acc_8_bit #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clear_acc (clear_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .acc       (acc),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        vclr;
    logic [15:0] exp_prod;
    logic [19:0] exp_acc;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[24];
  int   n_vecs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT in IDLE and out_ready=1.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tclr,
                        input logic [15:0] ep, input logic [19:0] ea, input logic eo,
                        input string tag);
    int lat;
    bit got;
    check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    clear_acc = tclr;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = 8'($urandom);
    b         = 8'($urandom);
    clear_acc = 1'($urandom);
    lat = 1;
    got = 0;
    while (lat <= 20) begin
      if (out_valid) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, got ? 32'(lat) : 32'hFFFF, 32'd10);
    check({tag, " product"}, 32'(product), 32'(ep));
    check({tag, " acc"}, 32'(acc), 32'(ea));
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    $display("op %s: %02h*%02h clr=%0b -> product=%04h acc=%05h ovf=%0b lat=%0d",
             tag, ta, tb, tclr, product, acc, overflow, lat);
    @(posedge clk); #1;
    check({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [19:0] model;
    logic [23:0] wide;
    int          accepts;
    int          outs;
    int          last_accept;
    logic [15:0] exp_p;
    logic [19:0] exp_a;
    bit          seen;

    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    clear_acc = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;

    // 0xFF*0xFF repeated 17 times, then a clearing 1*1, then a mixed tail.
    n_vecs = 0;
    for (int k = 1; k <= 17; k++) begin
      wide = 24'(k) * 24'hFE01;
      vecs[n_vecs] = '{8'hFF, 8'hFF, (k == 1), 16'hFE01, wide[19:0], (wide[23:20] != 4'd0)};
      n_vecs++;
    end
    vecs[n_vecs++] = '{8'h01, 8'h01, 1'b1, 16'h0001, 20'h00001, 1'b0};
    vecs[n_vecs++] = '{8'h04, 8'h04, 1'b1, 16'h0010, 20'h00010, 1'b0};
    vecs[n_vecs++] = '{8'h00, 8'hAB, 1'b0, 16'h0000, 20'h00010, 1'b0};
    vecs[n_vecs++] = '{8'h0F, 8'h11, 1'b0, 16'h00FF, 20'h0010F, 1'b0};
    vecs[n_vecs++] = '{8'hA5, 8'h3C, 1'b0, 16'h26AC, 20'h027BB, 1'b0};
    vecs[n_vecs++] = '{8'hAB, 8'h00, 1'b1, 16'h0000, 20'h00000, 1'b0};

    // Reset state, with inputs active during reset.
    in_valid = 1'b1;
    a        = 8'h12;
    b        = 8'h34;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset product", 32'(product), 32'd0);
    check("reset acc", 32'(acc), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    check("post-reset product", 32'(product), 32'd0);

    // Spot-check the two named accumulator milestones from the table.
    check("table row16 acc", 32'(vecs[15].exp_acc), 32'h0FE010);
    check("table row17 acc", 32'(vecs[16].exp_acc), 32'h00DE11);

    for (int i = 0; i < n_vecs; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vclr, vecs[i].exp_prod,
             vecs[i].exp_acc, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Downstream stall: result must hold, in_valid pulse must be ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a         = 8'h80;
    b         = 8'h02;
    clear_acc = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("stall out_valid reached", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall product", 32'(product), 32'h0100);
      check("stall acc", 32'(acc), 32'h00100);
      check("stall in_ready", 32'(in_ready), 32'd0);
      in_valid = (i == 2);
      a        = 8'h07;
      b        = 8'h07;
      clear_acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall released out_valid", 32'(out_valid), 32'd0);
    check("stall released in_ready", 32'(in_ready), 32'd1);
    $display("op stall: 80*02 held 5 cycles, product=%04h acc=%05h", product, acc);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid || !in_ready) seen = 1;
      @(posedge clk); #1;
    end
    check("stall no queued op", 32'(seen), 32'd0);
    check("stall acc unchanged", 32'(acc), 32'h00100);

    // Reset in the 4th MUL cycle aborts the operation.
    in_valid  = 1'b1;
    a         = 8'h0F;
    b         = 8'h0F;
    clear_acc = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort product", 32'(product), 32'd0);
    check("abort acc", 32'(acc), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    check("abort no out_valid", 32'(seen), 32'd0);
    $display("op abort: reset during MUL, acc=%05h", acc);
    run_op(8'h03, 8'h05, 1'b0, 16'h000F, 20'h0000F, 1'b0, "after_abort");

    // Back-to-back: in_valid held high, one acceptance every 11 cycles.
    model       = '0;
    accepts     = 0;
    outs        = 0;
    last_accept = -1;
    exp_p       = '0;
    exp_a       = '0;
    in_valid    = 1'b1;
    clear_acc   = 1'b1;
    a           = 8'hC3;
    b           = 8'h5A;
    for (int cyc = 0; cyc <= 65; cyc++) begin
      if (out_valid) begin
        outs++;
        check("stream product", 32'(product), 32'(exp_p));
        check("stream acc", 32'(acc), 32'(exp_a));
        $display("op stream out %0d: product=%04h acc=%05h", outs, product, acc);
      end
      if (in_ready) begin
        if (last_accept >= 0) check("stream interval", 32'(cyc - last_accept), 32'd11);
        last_accept = cyc;
        accepts++;
        exp_p = 16'(a) * 16'(b);
        model = (clear_acc ? 20'd0 : model) + 20'(exp_p);
        exp_a = model;
      end
      @(posedge clk); #1;
      if (last_accept >= 0) clear_acc = 1'b0;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
    end
    in_valid = 1'b0;
    check("stream accepts", 32'(accepts), 32'd6);
    check("stream outs", 32'(outs), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
